// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester C/D handshakes plus the bridge-side bus of the arbiter
// Ports (all in the bundle):
//   requesters  c_/d_req, c_/d_addr, c_/d_wdata, c_/d_byteen in; c_/d_done, c_/d_rdata out
//   bridge      bus_addr, bus_wdata, bus_byteen out; bus_rdata in
//   status      busy, owner out
// slave = arbiter side, master = requester/bridge environment side.
interface bus_arbiter_if;
  logic        c_req, d_req;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_byteen, d_byteen;
  logic        c_done, d_done;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;
  logic        busy, owner;
  modport slave (
    input  c_req, c_addr, c_wdata, c_byteen, d_req, d_addr, d_wdata, d_byteen, bus_rdata,
    output c_done, c_rdata, d_done, d_rdata, bus_addr, bus_wdata, bus_byteen, busy, owner
  );
  modport master (
    output c_req, c_addr, c_wdata, c_byteen, d_req, d_addr, d_wdata, d_byteen, bus_rdata,
    input  c_done, c_rdata, d_done, d_rdata, bus_addr, bus_wdata, bus_byteen, busy, owner
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the bridge bus between CPU (C) and DMA (D) with IDLE->ADDR->DATA transactions
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bif      bus_arbiter_if.slave: requester handshakes, bridge bus, busy/owner status
// Parameters: CPU_PRIO (1 = C wins conflicts, 0 = round-robin), STARVE_MAX (C conflict wins before D is forced)
module bus_arbiter #(
  parameter bit CPU_PRIO   = 1'b1,
  parameter int STARVE_MAX = 4
) (
  input logic      clk,
  input logic      reset_n,
  bus_arbiter_if.slave bif
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          c_elig, d_elig, grant, pick_d;
  // The cycle a done pulse is out is a turnaround: nobody is granted, so the
  // requester that just finished competes for the next slot alongside the other.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant      = 1'b0;
    pick_d     = 1'b0;
    c_elig     = bif.c_req && !bif.c_done && !bif.d_done;
    d_elig     = bif.d_req && !bif.d_done && !bif.c_done;
    case (state)
      IDLE: if (c_elig || d_elig) begin
        grant     = 1'b1;
        state_nxt = ADDR;
        if (c_elig && d_elig) begin
          if (starve_cnt == SW'(STARVE_MAX)) pick_d = 1'b1;
          else if (CPU_PRIO) starve_nxt = starve_cnt + 1'b1;
          else pick_d = !bif.owner;
        end else pick_d = d_elig;
        if (pick_d) starve_nxt = '0;
      end
      ADDR:    state_nxt = DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      bif.bus_addr   <= '0;
      bif.bus_wdata  <= '0;
      bif.bus_byteen <= '0;
      bif.c_done     <= 1'b0;
      bif.d_done     <= 1'b0;
      bif.c_rdata    <= '0;
      bif.d_rdata    <= '0;
      bif.owner      <= 1'b0;
      bif.busy       <= 1'b0;
    end else begin
      state          <= state_nxt;
      starve_cnt     <= starve_nxt;
      bif.busy       <= state_nxt != IDLE;
      bif.bus_byteen <= '0;
      bif.c_done     <= 1'b0;
      bif.d_done     <= 1'b0;
      if (grant) begin
        bif.owner      <= pick_d;
        bif.bus_addr   <= pick_d ? bif.d_addr : bif.c_addr;
        bif.bus_wdata  <= pick_d ? bif.d_wdata : bif.c_wdata;
        bif.bus_byteen <= pick_d ? bif.d_byteen : bif.c_byteen;
      end
      if (state == DATA) begin
        if (bif.owner) begin
          bif.d_done  <= 1'b1;
          bif.d_rdata <= bif.bus_rdata;
        end else begin
          bif.c_done  <= 1'b1;
          bif.c_rdata <= bif.bus_rdata;
        end
      end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for a CPU-priority and a round-robin bus_arbiter fed identical stimulus
module tb_bus_arbiter;
  typedef struct {
    logic        who;
    int          cyc;
    logic [31:0] rd;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t;
  exp_t q_p[$];
  exp_t q_r[$];
  bus_arbiter_if ifp ();
  bus_arbiter_if ifr ();
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ifp.bus_rdata = (ifp.bus_addr == 32'h1004) ? 32'hDEADBEEF : ~ifp.bus_addr;
  assign ifr.bus_rdata = (ifr.bus_addr == 32'h1004) ? 32'hDEADBEEF : ~ifr.bus_addr;
  bus_arbiter #(.CPU_PRIO(1'b1), .STARVE_MAX(4)) u_pri (.clk(clk), .reset_n(reset_n), .bif(ifp.slave));
  bus_arbiter #(.CPU_PRIO(1'b0), .STARVE_MAX(4)) u_rr  (.clk(clk), .reset_n(reset_n), .bif(ifr.slave));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask
  task automatic chk2(input string nm, input logic [31:0] act_p, input logic [31:0] act_r, input logic [31:0] exp);
    chk({"pri.", nm}, act_p, exp);
    chk({"rr.", nm}, act_r, exp);
  endtask
  task automatic cmp_done(input string nm, input bit empty, input exp_t e, input logic cd, input logic dd,
                          input logic [31:0] cr, input logic [31:0] dr);
    n_chk++;
    if (empty) begin
      n_fail++;
      $display("FAIL %s.done @cyc %0d: got c_done=%0b d_done=%0b want no done", nm, cyc, cd, dd);
    end else if ((cd && dd) || dd !== e.who || cyc != e.cyc || (dd ? dr : cr) !== e.rd) begin
      n_fail++;
      $display("FAIL %s.done @cyc %0d: got c_done=%0b d_done=%0b rdata=%h want owner=%0b cyc=%0d rdata=%h",
               nm, cyc, cd, dd, dd ? dr : cr, e.who, e.cyc, e.rd);
    end
  endtask
  always @(negedge clk)
    if (reset_n && (ifp.c_done || ifp.d_done)) begin
      exp_t e;
      bit   em;
      e  = '{1'b0, 0, 32'h0};
      em = q_p.size() == 0;
      if (!em) e = q_p.pop_front();
      cmp_done("pri", em, e, ifp.c_done, ifp.d_done, ifp.c_rdata, ifp.d_rdata);
    end
  always @(negedge clk)
    if (reset_n && (ifr.c_done || ifr.d_done)) begin
      exp_t e;
      bit   em;
      e  = '{1'b0, 0, 32'h0};
      em = q_r.size() == 0;
      if (!em) e = q_r.pop_front();
      cmp_done("rr", em, e, ifr.c_done, ifr.d_done, ifr.c_rdata, ifr.d_rdata);
    end
  task automatic set_c(input logic r, input logic [31:0] a, input logic [31:0] w, input logic [3:0] b);
    ifp.c_req = r; ifp.c_addr = a; ifp.c_wdata = w; ifp.c_byteen = b;
    ifr.c_req = r; ifr.c_addr = a; ifr.c_wdata = w; ifr.c_byteen = b;
  endtask
  task automatic set_d(input logic r, input logic [31:0] a, input logic [31:0] w, input logic [3:0] b);
    ifp.d_req = r; ifp.d_addr = a; ifp.d_wdata = w; ifp.d_byteen = b;
    ifr.d_req = r; ifr.d_addr = a; ifr.d_wdata = w; ifr.d_byteen = b;
  endtask
  task automatic exp_both(input logic who_p, input logic who_r, input int c,
                          input logic [31:0] rp, input logic [31:0] rr);
    q_p.push_back('{who_p, c, rp});
    q_r.push_back('{who_r, c, rr});
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    reset_n = 1'b0;
    set_c(1'b0, 32'h0, 32'h0, 4'h0);
    set_d(1'b0, 32'h0, 32'h0, 4'h0);
    tick(3);
    chk2("rst.bus_addr", ifp.bus_addr, ifr.bus_addr, 32'h0);
    chk2("rst.bus_wdata", ifp.bus_wdata, ifr.bus_wdata, 32'h0);
    chk2("rst.bus_byteen", 32'(ifp.bus_byteen), 32'(ifr.bus_byteen), 32'h0);
    chk2("rst.c_done", 32'(ifp.c_done), 32'(ifr.c_done), 32'h0);
    chk2("rst.d_done", 32'(ifp.d_done), 32'(ifr.d_done), 32'h0);
    chk2("rst.c_rdata", ifp.c_rdata, ifr.c_rdata, 32'h0);
    chk2("rst.d_rdata", ifp.d_rdata, ifr.d_rdata, 32'h0);
    chk2("rst.owner", 32'(ifp.owner), 32'(ifr.owner), 32'h0);
    chk2("rst.busy", 32'(ifp.busy), 32'(ifr.busy), 32'h0);
    reset_n = 1'b1;
    tick(2);
    t = cyc;
    set_c(1'b1, 32'h1004, 32'h0, 4'h0);
    exp_both(1'b0, 1'b0, t + 3, 32'hDEADBEEF, 32'hDEADBEEF);
    tick(1);
    chk2("c_rd.addr_c1", ifp.bus_addr, ifr.bus_addr, 32'h1004);
    chk2("c_rd.busy_c1", 32'(ifp.busy), 32'(ifr.busy), 32'h1);
    chk2("c_rd.byteen_c1", 32'(ifp.bus_byteen), 32'(ifr.bus_byteen), 32'h0);
    tick(1);
    chk2("c_rd.addr_c2", ifp.bus_addr, ifr.bus_addr, 32'h1004);
    chk2("c_rd.busy_c2", 32'(ifp.busy), 32'(ifr.busy), 32'h1);
    tick(1);
    set_c(1'b0, 32'h0, 32'h0, 4'h0);
    tick(1);
    chk2("c_rd.done_c4", 32'(ifp.c_done), 32'(ifr.c_done), 32'h0);
    chk2("c_rd.rdata_c4", ifp.c_rdata, ifr.c_rdata, 32'hDEADBEEF);
    chk2("c_rd.busy_c4", 32'(ifp.busy), 32'(ifr.busy), 32'h0);
    tick(2);
    t = cyc;
    set_d(1'b1, 32'h7F00, 32'h12345678, 4'hF);
    exp_both(1'b1, 1'b1, t + 3, 32'hFFFF80FF, 32'hFFFF80FF);
    tick(1);
    chk2("d_wr.byteen_c1", 32'(ifp.bus_byteen), 32'(ifr.bus_byteen), 32'hF);
    chk2("d_wr.wdata_c1", ifp.bus_wdata, ifr.bus_wdata, 32'h12345678);
    chk2("d_wr.addr_c1", ifp.bus_addr, ifr.bus_addr, 32'h7F00);
    chk2("d_wr.owner_c1", 32'(ifp.owner), 32'(ifr.owner), 32'h1);
    tick(1);
    chk2("d_wr.byteen_c2", 32'(ifp.bus_byteen), 32'(ifr.bus_byteen), 32'h0);
    chk2("d_wr.addr_c2", ifp.bus_addr, ifr.bus_addr, 32'h7F00);
    tick(1);
    set_d(1'b0, 32'h0, 32'h0, 4'h0);
    tick(1);
    chk2("d_wr.owner_c4", 32'(ifp.owner), 32'(ifr.owner), 32'h1);
    chk2("d_wr.rdata_c4", ifp.d_rdata, ifr.d_rdata, 32'hFFFF80FF);
    chk2("d_wr.done_c4", 32'(ifp.d_done), 32'(ifr.d_done), 32'h0);
    tick(2);
    t = cyc;
    set_c(1'b1, 32'h100, 32'h0, 4'h0);
    set_d(1'b1, 32'h200, 32'h0, 4'h0);
    for (int k = 0; k < 10; k++) begin
      logic wp, wr;
      wp = (k % 5) == 4;
      wr = (k % 2) == 1;
      exp_both(wp, wr, t + 3 + 4 * k, wp ? 32'hFFFFFDFF : 32'hFFFFFEFF, wr ? 32'hFFFFFDFF : 32'hFFFFFEFF);
    end
    tick(39);
    set_c(1'b0, 32'h0, 32'h0, 4'h0);
    set_d(1'b0, 32'h0, 32'h0, 4'h0);
    tick(3);
    set_c(1'b1, 32'h300, 32'hCAFE0000, 4'h3);
    tick(2);
    chk2("rst_mid.busy_data", 32'(ifp.busy), 32'(ifr.busy), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk2("rst_mid.byteen", 32'(ifp.bus_byteen), 32'(ifr.bus_byteen), 32'h0);
    chk2("rst_mid.addr", ifp.bus_addr, ifr.bus_addr, 32'h0);
    chk2("rst_mid.busy", 32'(ifp.busy), 32'(ifr.busy), 32'h0);
    tick(2);
    chk2("rst_mid.c_done", 32'(ifp.c_done), 32'(ifr.c_done), 32'h0);
    reset_n = 1'b1;
    t = cyc;
    exp_both(1'b0, 1'b0, t + 3, 32'hFFFFFCFF, 32'hFFFFFCFF);
    tick(1);
    chk2("rst_mid.restart_busy", 32'(ifp.busy), 32'(ifr.busy), 32'h1);
    chk2("rst_mid.restart_addr", ifp.bus_addr, ifr.bus_addr, 32'h300);
    chk2("rst_mid.restart_byteen", 32'(ifp.bus_byteen), 32'(ifr.bus_byteen), 32'h3);
    tick(2);
    set_c(1'b0, 32'h0, 32'h0, 4'h0);
    tick(3);
    t = cyc;
    set_c(1'b1, 32'h400, 32'h0, 4'h0);
    exp_both(1'b0, 1'b0, t + 3, 32'hFFFFFBFF, 32'hFFFFFBFF);
    tick(4);
    set_c(1'b1, 32'h404, 32'h0, 4'h0);
    exp_both(1'b0, 1'b0, t + 7, 32'hFFFFFBFB, 32'hFFFFFBFB);
    chk2("b2b.busy_c4", 32'(ifp.busy), 32'(ifr.busy), 32'h0);
    tick(1);
    chk2("b2b.busy_c5", 32'(ifp.busy), 32'(ifr.busy), 32'h1);
    chk2("b2b.addr_c5", ifp.bus_addr, ifr.bus_addr, 32'h404);
    tick(2);
    set_c(1'b0, 32'h0, 32'h0, 4'h0);
    tick(4);
    chk("pri.pending_dones", 32'(q_p.size()), 32'h0);
    chk("rr.pending_dones", 32'(q_r.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
